// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit.
// Moore-decoded datapath controls for fetch/decode/execute/memory/writeback,
// including the extended ops (bn, balmn, jrsal, jmadd, balrz) and jr.
// Memory states wait on mem_ready with an optional bounded timeout. Illegal
// opcodes, timeouts and unused state encodings all fall into a sticky TRAP.
// Handshake: a memory access is held (strobe and address select stable)
// until mem_ready is sampled high on a rising clock edge. That same edge
// completes the access. mem_ready is ignored outside memory states.
module multicycle_control #(
   parameter int OP_W        = 6,
   parameter int FN_W        = 6,
   parameter int MEM_TIMEOUT = 15,
   parameter int EXT_EN      = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OP_W-1:0] op,
   input  logic [FN_W-1:0] funct,
   input  logic            mem_ready,
   input  logic            zero,
   input  logic            neg_flag,
   input  logic            zero_flag,
   output logic            pc_write,
   output logic [1:0]      pc_source,
   output logic [1:0]      iord,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ir_write,
   output logic [1:0]      reg_dst,
   output logic [1:0]      mem_to_reg,
   output logic            reg_write,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic            status_write,
   output logic [3:0]      state_o,
   output logic            error
);

   // State encodings (exposed on state_o for debug).
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_REXEC  = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JREG   = 4'd9;
   localparam logic [3:0] S_JMRD   = 4'd10;
   localparam logic [3:0] S_JMJMP  = 4'd11;
   localparam logic [3:0] S_TRAP   = 4'd12;

   // Opcode and funct values.
   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
   localparam logic [OP_W-1:0] OP_BN    = OP_W'(6'h25);
   localparam logic [OP_W-1:0] OP_BALMN = OP_W'(6'h24);
   localparam logic [OP_W-1:0] OP_JRSAL = OP_W'(6'h19);
   localparam logic [FN_W-1:0] FN_JR    = FN_W'(6'h08);
   localparam logic [FN_W-1:0] FN_JMADD = FN_W'(6'h32);
   localparam logic [FN_W-1:0] FN_BALRZ = FN_W'(6'h16);

   // Wait timer sizing; a zero timeout means wait forever.
   localparam int             TW         = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0]  TMAX       = TW'(MEM_TIMEOUT);
   localparam logic           TIMEOUT_EN = (MEM_TIMEOUT != 0);
   localparam logic           EXT        = (EXT_EN != 0);

   logic [3:0]    r_state;
   logic [3:0]    w_next;
   logic [TW-1:0] r_timer;
   logic          r_error;

   // Instruction decode. Extended ops are gated by EXT so that they decode
   // as illegal when the extension is disabled.
   logic w_op_r, w_op_lw, w_op_sw, w_op_beq, w_op_bn, w_op_balmn, w_op_jrsal;
   logic w_is_jr, w_is_jmadd, w_is_balrz, w_fn_ext_raw, w_r_normal;
   logic w_mem_state, w_timeout;

   assign w_op_r       = (op == OP_RTYPE);
   assign w_op_lw      = (op == OP_LW);
   assign w_op_sw      = (op == OP_SW);
   assign w_op_beq     = (op == OP_BEQ);
   assign w_op_bn      = (op == OP_BN) && EXT;
   assign w_op_balmn   = (op == OP_BALMN) && EXT;
   assign w_op_jrsal   = (op == OP_JRSAL) && EXT;
   assign w_is_jr      = w_op_r && (funct == FN_JR);
   assign w_is_jmadd   = w_op_r && (funct == FN_JMADD) && EXT;
   assign w_is_balrz   = w_op_r && (funct == FN_BALRZ) && EXT;
   // Extended functs never fall through to plain R-type execution, even
   // when disabled; they must trap instead.
   assign w_fn_ext_raw = (funct == FN_JMADD) || (funct == FN_BALRZ);
   assign w_r_normal   = w_op_r && (funct != FN_JR) && !w_fn_ext_raw;

   // Memory-wait states and timeout qualifier. A coincident mem_ready
   // completes the access rather than timing out.
   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR) || (r_state == S_JMRD);
   assign w_timeout   = TIMEOUT_EN && w_mem_state && !mem_ready && (r_timer == TMAX);

   // Next-state selection.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (mem_ready)      w_next = S_DECODE;
            else if (w_timeout) w_next = S_TRAP;
         end
         S_DECODE: begin
            if (w_op_lw || w_op_sw || w_op_balmn) w_next = S_MEMADR;
            else if (w_r_normal)                  w_next = S_REXEC;
            else if (w_is_jr || w_is_balrz)       w_next = S_JREG;
            else if (w_is_jmadd || w_op_jrsal)    w_next = S_JMRD;
            else if (w_op_beq || w_op_bn)         w_next = S_BRANCH;
            else                                  w_next = S_TRAP;
         end
         S_MEMADR: w_next = w_op_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (mem_ready)      w_next = S_MEMWB;
            else if (w_timeout) w_next = S_TRAP;
         end
         S_MEMWB:  w_next = S_FETCH;
         S_MEMWR: begin
            if (mem_ready)      w_next = S_FETCH;
            else if (w_timeout) w_next = S_TRAP;
         end
         S_REXEC:  w_next = S_RWB;
         S_RWB:    w_next = S_FETCH;
         S_BRANCH: w_next = S_FETCH;
         S_JREG:   w_next = S_FETCH;
         S_JMRD: begin
            if (mem_ready)      w_next = S_JMJMP;
            else if (w_timeout) w_next = S_TRAP;
         end
         S_JMJMP:  w_next = S_FETCH;
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_TRAP;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Wait-cycle timer: counts stalled memory cycles, restarts on any state change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_timer <= '0;
      else if (w_next != r_state)
         r_timer <= '0;
      else if (TIMEOUT_EN && w_mem_state && !mem_ready && (r_timer != TMAX))
         r_timer <= r_timer + 1'b1;
   end

   // Sticky error flag, raised on the edge that enters TRAP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 r_error <= 1'b0;
      else if (w_next == S_TRAP) r_error <= 1'b1;
   end

   // Moore output decode with combinational qualifiers.
   always_comb begin
      pc_write     = 1'b0;
      pc_source    = 2'b00;
      iord         = 2'b00;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_dst      = 2'b00;
      mem_to_reg   = 2'b00;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_op       = 2'b00;
      status_write = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 2'b01;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            pc_write   = w_op_balmn && neg_flag;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 2'b01;
         end
         S_REXEC: begin
            alu_src_a    = 1'b1;
            alu_op       = 2'b10;
            status_write = 1'b1;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 2'b01;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_source = 2'b01;
            pc_write  = w_op_beq ? zero : (w_op_bn && neg_flag);
         end
         S_JREG: begin
            pc_source = 2'b11;
            if (w_is_balrz) begin
               pc_write   = zero_flag;
               reg_write  = zero_flag;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
            end else begin
               pc_write = w_is_jr;
            end
         end
         S_JMRD: begin
            mem_read = 1'b1;
            iord     = 2'b10;
         end
         S_JMJMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            if (w_op_jrsal) begin
               reg_write  = 1'b1;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
            end
         end
         default: ;
      endcase
   end

   assign state_o = r_state;
   assign error   = r_error;

endmodule
